pw_timer_arbiter: RTL and testbench

Round-robin arbiter sharing one pulse-width timer (start/width-load/busy-output style) among `NREQ` requesters. Each requester supplies its own pulse width. The arbiter grants one requester at a time and issues a one-cycle start with that width. It then tracks the timer's pulse output to completion, returns a per-requester done strobe, and inserts a programmable guard gap before the next grant. It sits between the channel logic and the single timer instance.

---
 rtl/pw_timer_arbiter.sv | 169 ++++++++++++++++
 tb/tb_pw_timer_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pw_timer_arbiter.sv
// Round-robin arbiter sharing one pulse-width timer among NREQ requesters.
// Grants one requester, starts the timer with its width, tracks the pulse to done, then guards.
module pw_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int Z    = 11,
  parameter int GAP  = 2,
  parameter int TMO  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*Z-1:0] mt_bus,
  input  logic              tmr_pw,
  output logic              tmr_st,
  output logic [Z-1:0]      tmr_mt,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + GAP + 2);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GUARD   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic [PW-1:0]   gidx_r, gidx_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] done_r, done_s;
  logic [Z-1:0]    mt_r, mt_s;
  logic            st_r, st_s;
  logic            err_r, err_s;
  logic            busy_r, busy_s;
  logic            sel_found_s;
  logic [PW-1:0]   sel_idx_s;

  // Rotating priority pick: first set request at or after ptr, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_found_s && req[(int'(ptr_r) + i) % NREQ]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = PW'((int'(ptr_r) + i) % NREQ);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gidx_s  = gidx_r;
    cnt_s   = cnt_r;
    gnt_s   = gnt_r;
    mt_s    = mt_r;
    st_s    = 1'b0;
    done_s  = '0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          gnt_s   = ONE << sel_idx_s;
          gidx_s  = sel_idx_s;
          mt_s    = mt_bus[int'(sel_idx_s)*Z +: Z];
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        cnt_s = '0;
        if (mt_r != '0) begin
          st_s    = 1'b1;
          state_s = WAIT_HI;
        end else begin
          done_s  = gnt_r;
          err_s   = 1'b1;
          state_s = GUARD;
        end
      end
      WAIT_HI: begin
        // A rising pulse wins over a timeout expiring on the same edge.
        if (tmr_pw) begin
          state_s = WAIT_LO;
        end else if (int'(cnt_r) >= TMO - 1) begin
          done_s  = gnt_r;
          err_s   = 1'b1;
          cnt_s   = '0;
          state_s = GUARD;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!tmr_pw) begin
          done_s  = gnt_r;
          cnt_s   = '0;
          state_s = GUARD;
        end else begin
          state_s = WAIT_LO;
        end
      end
      GUARD: begin
        if (int'(cnt_r) >= GAP - 1) begin
          gnt_s   = '0;
          cnt_s   = '0;
          ptr_s   = (gidx_r == PW'(NREQ - 1)) ? '0 : gidx_r + PW'(1);
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        gnt_s   = '0;
        cnt_s   = '0;
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      gidx_r  <= '0;
      cnt_r   <= '0;
      gnt_r   <= '0;
      mt_r    <= '0;
      st_r    <= 1'b0;
      done_r  <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gidx_r  <= gidx_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
      mt_r    <= mt_s;
      st_r    <= st_s;
      done_r  <= done_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
    end
  end

  assign tmr_st = st_r;
  assign tmr_mt = mt_r;
  assign gnt    = gnt_r;
  assign done   = done_r;
  assign err    = err_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_pw_timer_arbiter.sv
// Directed self-checking bench for pw_timer_arbiter with a behavioural pulse-width timer model.
module tb_pw_timer_arbiter;

  localparam int NREQ = 4;
  localparam int Z    = 11;
  localparam int GAP  = 2;
  localparam int TMO  = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*Z-1:0] mt_bus;
  logic              tmr_pw = 1'b0;
  logic              tmr_st;
  logic [Z-1:0]      tmr_mt;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              busy;

  logic              tmr_dead = 1'b0;
  logic [Z-1:0]      tcnt = '0;
  int                n_asserts = 0;
  int                n_fail = 0;

  pw_timer_arbiter #(.NREQ(NREQ), .Z(Z), .GAP(GAP), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mt_bus(mt_bus), .tmr_pw(tmr_pw),
    .tmr_st(tmr_st), .tmr_mt(tmr_mt), .gnt(gnt), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Timer model: pulse rises the edge after a start and stays high for tmr_mt clocks.
  always @(posedge clk) begin
    if (tmr_st && !tmr_dead) begin
      tcnt   <= tmr_mt;
      tmr_pw <= 1'b1;
    end else if (tcnt > 1) begin
      tcnt <= tcnt - 1;
    end else begin
      tcnt   <= '0;
      tmr_pw <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input int w);
    mt_bus[i*Z +: Z] = Z'(w);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nst;
    int last_done;
    logic [NREQ-1:0] exp_g;
    rst_n  = 1'b0;
    req    = '0;
    mt_bus = '0;
    tick(); tick();
    chk("rst_gnt", gnt, 0); chk("rst_st", tmr_st, 0); chk("rst_mt", tmr_mt, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Single request, width 5
    req = 4'b0001; setw(0, 5);
    tick(); chk("s_gnt", gnt, 4'b0001); chk("s_st_lat", tmr_st, 0); chk("s_busy", busy, 1);
    tick(); chk("s_st", tmr_st, 1); chk("s_mt", tmr_mt, 5);
    tick(); chk("s_st_one", tmr_st, 0);
    repeat (5) tick();
    chk("s_done_early", done, 0);
    tick(); chk("s_done", done, 4'b0001); chk("s_err", err, 0);
    req = '0;
    tick(); chk("s_guard_gnt", gnt, 4'b0001); chk("s_done_one", done, 0);
    tick(); chk("s_free_gnt", gnt, 0); chk("s_free_busy", busy, 0); chk("s_mt_hold", tmr_mt, 5);

    // Zero width on requester 1
    req = 4'b0010; setw(1, 0);
    tick(); chk("z_gnt", gnt, 4'b0010);
    tick(); chk("z_st", tmr_st, 0); chk("z_done", done, 4'b0010); chk("z_err", err, 1);
    req = '0;
    tick(); chk("z_done_one", done, 0); chk("z_err_one", err, 0); chk("z_guard", gnt, 4'b0010);
    tick(); chk("z_free", gnt, 0);

    // Pointer fairness: serve 2, then 0101 must give 0 then 2
    req = 4'b0100; setw(2, 3);
    tick(); chk("f_gnt2a", gnt, 4'b0100);
    tick(); chk("f_st2a", tmr_st, 1);
    repeat (4) tick();
    tick(); chk("f_done2a", done, 4'b0100);
    req = '0;
    tick(); tick(); chk("f_free2a", gnt, 0);
    req = 4'b0101; setw(0, 2);
    tick(); chk("f_gnt0", gnt, 4'b0001);
    tick(); chk("f_st0", tmr_st, 1); chk("f_mt0", tmr_mt, 2);
    repeat (3) tick();
    tick(); chk("f_done0", done, 4'b0001);
    req = 4'b0100;
    tick(); tick(); chk("f_free0", gnt, 0);
    tick(); chk("f_gnt2b", gnt, 4'b0100);
    tick(); chk("f_mt2b", tmr_mt, 3);
    repeat (4) tick();
    tick(); chk("f_done2b", done, 4'b0100);
    req = '0;
    tick(); tick(); chk("f_free2b", gnt, 0);

    // Timeout on requester 3, then recovery serving requester 0
    tmr_dead = 1'b1;
    req = 4'b1001; setw(3, 4);
    tick(); chk("t_gnt", gnt, 4'b1000);
    tick(); chk("t_st", tmr_st, 1);
    repeat (6) tick();
    chk("t_done_early", done, 0);
    tick(); chk("t_done", done, 4'b1000); chk("t_err", err, 1);
    req = 4'b0001; tmr_dead = 1'b0; setw(0, 2);
    tick(); tick(); chk("t_free", gnt, 0);
    tick(); chk("t_recover", gnt, 4'b0001);
    tick(); chk("t_rec_st", tmr_st, 1); chk("t_rec_mt", tmr_mt, 2);
    repeat (3) tick();
    tick(); chk("t_rec_done", done, 4'b0001); chk("t_rec_err", err, 0);

    // Reset in the middle of a pulse (requester 1 in WAIT_LO)
    req = 4'b0010; setw(1, 9);
    tick(); tick(); chk("r_free", gnt, 0);
    tick(); chk("r_gnt", gnt, 4'b0010);
    tick(); chk("r_st", tmr_st, 1); chk("r_mt", tmr_mt, 9);
    tick(); tick(); chk("r_busy_pre", busy, 1); chk("r_pw_pre", tmr_pw, 1);
    #1 rst_n = 1'b0; req = '0;
    #1;
    chk("r_gnt0", gnt, 0); chk("r_busy0", busy, 0); chk("r_mt0", tmr_mt, 0);
    chk("r_st0", tmr_st, 0); chk("r_done0", done, 0); chk("r_err0", err, 0);
    repeat (12) tick();
    rst_n = 1'b1;
    tick(); chk("r_idle_gnt", gnt, 0);

    // Round robin from ptr=0 with 1111 held, widths 1..4
    setw(0, 1); setw(1, 2); setw(2, 3); setw(3, 4);
    req = 4'b1111;
    nst = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 200 && nst < 6; cyc++) begin
      tick();
      if (tmr_st) begin
        exp_g = 4'b0001 << (nst % 4);
        chk("rr_order", gnt, exp_g);
        chk("rr_mt", tmr_mt, (nst % 4) + 1);
        if (last_done >= 0) chk("rr_gap", cyc - last_done, GAP + 2);
        nst++;
      end
      if (done != '0) begin
        chk("rr_done", done, gnt);
        chk("rr_err", err, 0);
        last_done = cyc;
      end
    end
    chk("rr_count", nst, 6);

    // Request drop mid-grant: the grant still completes with done
    req = '0;
    nst = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (done != '0) begin
        chk("drop_done", done, 4'b0010);
        nst++;
      end
    end
    chk("drop_seen", nst, 1);
    chk("drop_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
